sdram_reader: RTL and testbench
===============================

# sdram_reader

Read-side counterpart of the host command path: streams a byte range out of SDRAM to the host over the bidirectional byte bus. It takes a start pulse with a word address, start-byte select and byte count, and issues 16-bit SDRAM read requests. Each word is split into bytes, low byte first, which is the same byte order the write path packs. A small word prefetch buffer keeps the host bus saturated while the next SDRAM read completes.

## Interface
- FIFO_DEPTH, 2: prefetch buffer depth in 16-bit words; power of two, ≥2.
- LEN_WIDTH, 16: width of byte-count input.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only when `active`=0, ignored otherwise.
- start_address  in  22  first SDRAM word address.
- start_high  in  1  1 = first byte sent is the high byte of the first word.
- length  in  LEN_WIDTH  byte count; 0 = complete immediately, no SDRAM access.
- active  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the last byte handshakes or the transfer aborts.
- aborted  out  1  valid with `done`; 1 = ended by `bus.closed`.
- ram  sdram_bus.controller  uses req, we, address, data_read, busy. Read data is valid on the first cycle `busy` is low after it was raised for a request.
- bus  bidir_bus.producer  uses wr_valid, wr_ready, wr_data[7:0], closed.

## Operation
- Reset values: active=0, done=0, aborted=0, ram.req=0, ram.we=0, ram.address=0, bus.wr_valid=0, bus.wr_data=0. The FIFO is empty.
- States:
  - IDLE: on `start`, latch address, byte phase and remaining count, then go to RUN. If `length`=0, pulse `done` and stay in IDLE.
  - RUN: the fetch engine and the output engine run concurrently.
  - DRAIN: the fetch engine is finished and the output engine empties the remaining bytes.
  - Return to IDLE with `done` after the last byte handshakes.
- Fetch engine:
  - Issues one `ram.req` pulse with `ram.we`=0 when all of these hold: no request is outstanding, `ram.busy`=0, FIFO free slots > 0, and words still to fetch > 0.
  - Words to fetch = ceil((length + start_high) / 2), computed at start with width LEN_WIDTH+1.
  - Address increments by 1 per request and wraps modulo 2^22.
  - On read completion, pushes `ram.data_read` into the FIFO.
- Output engine:
  - Presents a byte from the FIFO head: low byte, then high byte. If `start_high`=1, the first word emits only its high byte.
  - Pops the word after its high byte handshakes, or early when the remaining byte count reaches 0 on a low byte.
  - Decrements the byte counter on each handshake.
- Abort: when `bus.closed`=1 while active, drop `wr_valid` next cycle, flush the FIFO, pulse `done` with `aborted`=1 and return to IDLE.
  - An outstanding SDRAM read is allowed to finish; its data is discarded.
  - A new `start` is ignored until that read finishes.

## Timing
- The first `ram.req` is asserted the cycle after `start` is accepted.
- The first `wr_valid` is asserted the cycle after the first read completes (FIFO push, registered output).
- Handshake rules:
  - `wr_valid`/`wr_data` stay stable until the cycle `wr_valid && wr_ready`.
  - Back-to-back bytes are allowed, one byte per cycle while the FIFO is non-empty.
  - `wr_valid` never depends combinationally on `wr_ready`.
- A FIFO push and pop in the same cycle are both performed.
  - When full, a simultaneous pop frees the slot for the next request, not for the current push. A push never overflows because requests are gated on free slots, counting the outstanding one.
- `done` is asserted the cycle after the final byte handshake.
  - `active` falls in that same cycle.
- Reset mid-transfer: all outputs take their reset values immediately (async). No `done` pulse.

## Structure
- `api_pkg`: command codes shared with the write path (CMD_WRITE=1, CMD_LOAD_DONE=2, CMD_READ=3), the reader state enum, and the SDRAM address width constant (22).
- Sub-module `word_fifo`: synchronous FIFO, parameterised by width and depth, with push/pop/full/empty/free-count. Used for the prefetch buffer.

## Test plan
- SDRAM words at 0x000100..0x000102 = 0x2211, 0x4433, 0x6655; start_address=0x000100, start_high=0, length=6, wr_ready tied 1 -> bytes 11 22 33 44 55 66, exactly 3 ram.req, done after the last byte, aborted=0.
- Same memory, start_high=1, length=3 -> bytes 22 33 44, only addresses 0x100 and 0x101 requested.
- length=5 with wr_ready toggling every other cycle and ram.busy held for 4 cycles per read -> bytes 11 22 33 44 55 stable under backpressure, never more than FIFO_DEPTH words fetched ahead.
- start_address=0x3FFFFF, length=4 -> requests to 0x3FFFFF then 0x000000.
- bus.closed asserted after the 2nd byte of a length=6 transfer -> wr_valid drops next cycle, done=1 with aborted=1. A start issued during the outstanding read is ignored. A new start issued afterwards runs cleanly.
- length=0 -> done one cycle after start, no ram.req, no wr_valid. reset_n pulsed low mid-transfer -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/api_pkg.sv
// Shared definitions for the host command path: command codes, reader FSM states and
// the SDRAM word-address width.
package api_pkg;

   localparam int unsigned SDRAM_ADDR_W = 22;

   localparam logic [7:0] CMD_WRITE     = 8'd1;
   localparam logic [7:0] CMD_LOAD_DONE = 8'd2;
   localparam logic [7:0] CMD_READ      = 8'd3;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } reader_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO with flush and free-slot count; used as the reader's word prefetch buffer.
module word_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_free
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_free  = CNT_W'(DEPTH) - r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // A full FIFO rejects a push even when a pop happens in the same cycle.
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_do_push && !w_do_pop) r_count <= r_count + CNT_W'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/sdram_reader.sv
// Streams a byte range from SDRAM to the host byte bus, low byte of each word first,
// with a small word prefetch buffer between the fetch and output engines.
module sdram_reader
   import api_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_start,
   input  logic [SDRAM_ADDR_W-1:0] i_start_address,
   input  logic                    i_start_high,
   input  logic [LEN_WIDTH-1:0]    i_length,
   output logic                    o_active,
   output logic                    o_done,
   output logic                    o_aborted,
   output logic                    o_ram_req,
   output logic                    o_ram_we,
   output logic [SDRAM_ADDR_W-1:0] o_ram_address,
   input  logic [15:0]             i_ram_data_read,
   input  logic                    i_ram_busy,
   output logic                    o_bus_wr_valid,
   input  logic                    i_bus_wr_ready,
   output logic [7:0]              o_bus_wr_data,
   input  logic                    i_bus_closed
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned AW    = SDRAM_ADDR_W;

   reader_state_e        r_state,         w_state_next;
   logic                 r_req,           w_req_next;
   logic [AW-1:0]        r_ram_address,   w_ram_address_next;
   logic [AW-1:0]        r_addr,          w_addr_next;
   logic                 r_outstanding,   w_outstanding_next;
   logic                 r_busy_seen,     w_busy_seen_next;
   logic [LEN_WIDTH:0]   r_words,         w_words_next;
   logic [LEN_WIDTH-1:0] r_remain,        w_remain_next;
   logic                 r_phase,         w_phase_next;
   logic                 r_done,          w_done_next;
   logic                 r_aborted,       w_aborted_next;

   logic [15:0]          w_fifo_data;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [CNT_W-1:0]     w_fifo_free;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_flush;

   logic [LEN_WIDTH:0]   w_bytes_sum;
   logic [LEN_WIDTH:0]   w_words_init;
   logic                 w_complete;
   logic                 w_wr_valid;
   logic                 w_hs;
   logic                 w_start_ok;
   logic                 w_can_fetch;

   word_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_reset_n),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (i_ram_data_read),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_free  (w_fifo_free)
   );

   // Words to fetch = ceil((length + start_high) / 2).
   assign w_bytes_sum  = {1'b0, i_length} + {{LEN_WIDTH{1'b0}}, i_start_high};
   assign w_words_init = (w_bytes_sum >> 1) + {{LEN_WIDTH{1'b0}}, w_bytes_sum[0]};

   assign w_complete  = r_outstanding & r_busy_seen & ~i_ram_busy;
   assign w_wr_valid  = (r_state != StIdle) & ~w_fifo_empty;
   assign w_hs        = w_wr_valid & i_bus_wr_ready;
   assign w_start_ok  = (r_state == StIdle) & i_start & ~r_outstanding;
   // Free slots must cover the read already in flight.
   assign w_can_fetch = ~r_outstanding & ~i_ram_busy & (r_words != '0) &
                        (w_fifo_free > CNT_W'(r_outstanding));

   always_comb begin
      w_state_next       = r_state;
      w_req_next         = 1'b0;
      w_ram_address_next = r_ram_address;
      w_addr_next        = r_addr;
      w_outstanding_next = r_outstanding;
      w_busy_seen_next   = r_busy_seen;
      w_words_next       = r_words;
      w_remain_next      = r_remain;
      w_phase_next       = r_phase;
      w_done_next        = 1'b0;
      w_aborted_next     = 1'b0;
      w_push             = 1'b0;
      w_pop              = 1'b0;
      w_flush            = 1'b0;

      if (r_outstanding && i_ram_busy) w_busy_seen_next = 1'b1;
      if (w_complete) begin
         w_outstanding_next = 1'b0;
         w_busy_seen_next   = 1'b0;
      end

      unique case (r_state)
         StIdle: begin
            if (w_start_ok) begin
               if (i_length == '0) begin
                  w_done_next = 1'b1;
               end else begin
                  w_state_next  = StRun;
                  w_remain_next = i_length;
                  w_phase_next  = i_start_high;
                  w_addr_next   = i_start_address;
                  w_words_next  = w_words_init;
                  if (!i_ram_busy) begin
                     w_req_next         = 1'b1;
                     w_ram_address_next = i_start_address;
                     w_addr_next        = i_start_address + AW'(1);
                     w_words_next       = w_words_init - (LEN_WIDTH + 1)'(1);
                     w_outstanding_next = 1'b1;
                  end
               end
            end
         end
         StRun, StDrain: begin
            if (i_bus_closed) begin
               // Any read still in flight completes in idle and is dropped there.
               w_state_next   = StIdle;
               w_flush        = 1'b1;
               w_done_next    = 1'b1;
               w_aborted_next = 1'b1;
            end else begin
               w_push = w_complete & ~w_fifo_full;
               if (r_state == StRun) begin
                  if (w_can_fetch) begin
                     w_req_next         = 1'b1;
                     w_ram_address_next = r_addr;
                     w_addr_next        = r_addr + AW'(1);
                     w_words_next       = r_words - (LEN_WIDTH + 1)'(1);
                     w_outstanding_next = 1'b1;
                  end else if (r_words == '0 && !r_outstanding) begin
                     w_state_next = StDrain;
                  end
               end
               if (w_hs) begin
                  w_remain_next = r_remain - LEN_WIDTH'(1);
                  if (r_phase) begin
                     w_pop        = 1'b1;
                     w_phase_next = 1'b0;
                  end else if (r_remain == LEN_WIDTH'(1)) begin
                     w_pop = 1'b1;
                  end else begin
                     w_phase_next = 1'b1;
                  end
                  if (r_remain == LEN_WIDTH'(1)) begin
                     w_state_next = StIdle;
                     w_done_next  = 1'b1;
                  end
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= StIdle;
         r_req         <= 1'b0;
         r_ram_address <= '0;
         r_addr        <= '0;
         r_outstanding <= 1'b0;
         r_busy_seen   <= 1'b0;
         r_words       <= '0;
         r_remain      <= '0;
         r_phase       <= 1'b0;
         r_done        <= 1'b0;
         r_aborted     <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_req         <= w_req_next;
         r_ram_address <= w_ram_address_next;
         r_addr        <= w_addr_next;
         r_outstanding <= w_outstanding_next;
         r_busy_seen   <= w_busy_seen_next;
         r_words       <= w_words_next;
         r_remain      <= w_remain_next;
         r_phase       <= w_phase_next;
         r_done        <= w_done_next;
         r_aborted     <= w_aborted_next;
      end
   end

   assign o_active       = (r_state != StIdle);
   assign o_done         = r_done;
   assign o_aborted      = r_aborted;
   assign o_ram_req      = r_req;
   assign o_ram_we       = 1'b0;
   assign o_ram_address  = r_ram_address;
   assign o_bus_wr_valid = w_wr_valid;
   assign o_bus_wr_data  = w_wr_valid ? (r_phase ? w_fifo_data[15:8] : w_fifo_data[7:0]) : 8'h00;

endmodule

// File: tb/tb_sdram_reader.sv
// Directed bench for sdram_reader: SDRAM latency model, bus ready driver and byte monitor.
module tb_sdram_reader;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [21:0] start_address = '0;
   logic        start_high = 1'b0;
   logic [15:0] length = '0;
   logic        active, done, aborted;
   logic        ram_req, ram_we;
   logic [21:0] ram_address;
   logic [15:0] ram_data_read;
   logic        ram_busy;
   logic        wr_valid;
   logic        wr_ready = 1'b1;
   logic [7:0]  wr_data;
   logic        closed = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int lat = 1;
   int rdy_mode = 0;
   int cyc = 0;

   logic [7:0]  rx_q[$];
   logic [21:0] req_q[$];
   int done_cnt, stab_err, max_ahead, valid_cnt, cur_sh, last_hs_cyc, done_cyc, we_err, ahead;
   bit last_aborted;
   bit prev_stall;
   logic [7:0] prev_data;
   int mcnt;
   logic [21:0] m_addr;

   sdram_reader #(
      .FIFO_DEPTH (DEPTH),
      .LEN_WIDTH  (16)
   ) dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_start         (start),
      .i_start_address (start_address),
      .i_start_high    (start_high),
      .i_length        (length),
      .o_active        (active),
      .o_done          (done),
      .o_aborted       (aborted),
      .o_ram_req       (ram_req),
      .o_ram_we        (ram_we),
      .o_ram_address   (ram_address),
      .i_ram_data_read (ram_data_read),
      .i_ram_busy      (ram_busy),
      .o_bus_wr_valid  (wr_valid),
      .i_bus_wr_ready  (wr_ready),
      .o_bus_wr_data   (wr_data),
      .i_bus_closed    (closed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [15:0] mem_word(input logic [21:0] a);
      case (a)
         22'h000100: return 16'h2211;
         22'h000101: return 16'h4433;
         22'h000102: return 16'h6655;
         22'h3FFFFF: return 16'hBBAA;
         22'h000000: return 16'hDDCC;
         default:    return 16'hEEEE;
      endcase
   endfunction

   // Busy for lat cycles after a request, data valid on the first non-busy cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_busy      <= 1'b0;
         ram_data_read <= 16'h0000;
         mcnt          <= 0;
         m_addr        <= '0;
      end else if (ram_req) begin
         ram_busy      <= 1'b1;
         mcnt          <= lat - 1;
         m_addr        <= ram_address;
         ram_data_read <= 16'h0000;
      end else if (ram_busy) begin
         if (mcnt == 0) begin
            ram_busy      <= 1'b0;
            ram_data_read <= mem_word(m_addr);
         end else begin
            mcnt <= mcnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       wr_ready = 1'b1;
         1:       wr_ready = ~wr_ready;
         default: wr_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (wr_valid) valid_cnt++;
      if (prev_stall && !(wr_valid === 1'b1 && wr_data === prev_data)) stab_err++;
      prev_stall = wr_valid && !wr_ready;
      prev_data  = wr_data;
      if (wr_valid && wr_ready) begin
         rx_q.push_back(wr_data);
         last_hs_cyc = cyc;
      end
      if (ram_req) begin
         req_q.push_back(ram_address);
         if (ram_we) we_err++;
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         last_aborted = aborted;
      end
      ahead = req_q.size() - (rx_q.size() + cur_sh) / 2;
      if (ahead > max_ahead) max_ahead = ahead;
   end

   task automatic clear();
      rx_q.delete();
      req_q.delete();
      done_cnt = 0; stab_err = 0; max_ahead = 0; valid_cnt = 0; we_err = 0;
      prev_stall = 1'b0; last_hs_cyc = -100; done_cyc = -1; last_aborted = 1'b0;
   endtask

   task automatic pulse_start(input logic [21:0] a, input logic h, input logic [15:0] l);
      @(negedge clk);
      start_address = a; start_high = h; length = l; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output bit timed_out);
      int base;
      base = done_cnt;
      timed_out = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != base) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({active, done, aborted, ram_req, ram_we, wr_valid} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 000000", {active, done, aborted, ram_req, ram_we, wr_valid});
      end
      n_vec++;
      if (ram_address !== 22'h0) begin
         n_err++; $display("FAIL reset_addr: got %h want 000000", ram_address);
      end
      n_vec++;
      if (wr_data !== 8'h00) begin
         n_err++; $display("FAIL reset_data: got %h want 00", wr_data);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_sequential();
      bit to;
      logic [7:0]  exp_b[$];
      logic [21:0] exp_a[$];
      logic [7:0]  g;
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      exp_a = '{22'h100, 22'h101, 22'h102};
      clear(); cur_sh = 0; lat = 1; rdy_mode = 0;
      pulse_start(22'h100, 1'b0, 16'd6);
      @(negedge clk);
      n_vec++;
      if (!(ram_req === 1'b1 && ram_address === 22'h100)) begin
         n_err++; $display("FAIL seq_first_req: got req=%b addr=%h want req=1 addr=000100", ram_req, ram_address);
      end
      wait_done(300, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL seq_timeout: done=0 want done within 300 cycles"); end
      n_vec++;
      if (active !== 1'b0) begin n_err++; $display("FAIL seq_active: got %b want 0", active); end
      n_vec++;
      if (rx_q.size() != exp_b.size()) begin
         n_err++; $display("FAIL seq_nbytes: got %0d want %0d", rx_q.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size(); i++) begin
         g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_vec++;
         if (g !== exp_b[i]) begin n_err++; $display("FAIL seq_byte%0d: got %h want %h", i, g, exp_b[i]); end
      end
      n_vec++;
      if (req_q != exp_a) begin n_err++; $display("FAIL seq_reqs: got %p want %p", req_q, exp_a); end
      n_vec++;
      if (last_aborted !== 1'b0) begin n_err++; $display("FAIL seq_aborted: got %b want 0", last_aborted); end
      n_vec++;
      if (done_cyc != last_hs_cyc + 1) begin
         n_err++; $display("FAIL seq_done_timing: got cycle %0d want %0d", done_cyc, last_hs_cyc + 1);
      end
      n_vec++;
      if (we_err != 0) begin n_err++; $display("FAIL seq_we: got %0d writes want 0", we_err); end
   endtask

   task automatic test_start_high();
      bit to;
      logic [7:0]  exp_b[$];
      logic [21:0] exp_a[$];
      logic [7:0]  g;
      exp_b = '{8'h22, 8'h33, 8'h44};
      exp_a = '{22'h100, 22'h101};
      clear(); cur_sh = 1; lat = 1; rdy_mode = 0;
      pulse_start(22'h100, 1'b1, 16'd3);
      wait_done(300, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL hi_timeout: done=0 want done within 300 cycles"); end
      n_vec++;
      if (rx_q.size() != exp_b.size()) begin
         n_err++; $display("FAIL hi_nbytes: got %0d want %0d", rx_q.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size(); i++) begin
         g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_vec++;
         if (g !== exp_b[i]) begin n_err++; $display("FAIL hi_byte%0d: got %h want %h", i, g, exp_b[i]); end
      end
      n_vec++;
      if (req_q != exp_a) begin n_err++; $display("FAIL hi_reqs: got %p want %p", req_q, exp_a); end
   endtask

   task automatic test_backpressure();
      bit to;
      logic [7:0]  exp_b[$];
      logic [7:0]  g;
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      clear(); cur_sh = 0; lat = 4; rdy_mode = 1;
      pulse_start(22'h100, 1'b0, 16'd5);
      wait_done(600, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL bp_timeout: done=0 want done within 600 cycles"); end
      for (int i = 0; i < exp_b.size(); i++) begin
         g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_vec++;
         if (g !== exp_b[i]) begin n_err++; $display("FAIL bp_byte%0d: got %h want %h", i, g, exp_b[i]); end
      end
      n_vec++;
      if (rx_q.size() != 5) begin n_err++; $display("FAIL bp_nbytes: got %0d want 5", rx_q.size()); end
      n_vec++;
      if (stab_err != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err); end
      n_vec++;
      if (max_ahead > DEPTH) begin n_err++; $display("FAIL bp_ahead: got %0d words ahead want <= %0d", max_ahead, DEPTH); end
      n_vec++;
      if (req_q.size() != 3) begin n_err++; $display("FAIL bp_nreqs: got %0d want 3", req_q.size()); end
      rdy_mode = 0; lat = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wrap();
      bit to;
      logic [7:0]  exp_b[$];
      logic [21:0] exp_a[$];
      logic [7:0]  g;
      exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      exp_a = '{22'h3FFFFF, 22'h000000};
      clear(); cur_sh = 0; lat = 1; rdy_mode = 0;
      pulse_start(22'h3FFFFF, 1'b0, 16'd4);
      wait_done(300, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL wrap_timeout: done=0 want done within 300 cycles"); end
      n_vec++;
      if (req_q != exp_a) begin n_err++; $display("FAIL wrap_reqs: got %p want %p", req_q, exp_a); end
      for (int i = 0; i < exp_b.size(); i++) begin
         g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
         n_vec++;
         if (g !== exp_b[i]) begin n_err++; $display("FAIL wrap_byte%0d: got %h want %h", i, g, exp_b[i]); end
      end
   endtask

   task automatic test_zero_len();
      clear(); cur_sh = 0;
      pulse_start(22'h100, 1'b0, 16'd0);
      @(negedge clk);
      n_vec++;
      if ({done, aborted, active} !== 3'b100) begin
         n_err++; $display("FAIL zero_done: got done/aborted/active=%b want 100", {done, aborted, active});
      end
      repeat (6) @(negedge clk);
      #1;
      n_vec++;
      if (done_cnt != 1) begin n_err++; $display("FAIL zero_ndone: got %0d want 1", done_cnt); end
      n_vec++;
      if (req_q.size() != 0 || valid_cnt != 0) begin
         n_err++; $display("FAIL zero_quiet: got %0d reqs %0d valid cycles want 0 0", req_q.size(), valid_cnt);
      end
   endtask

   task automatic test_abort();
      bit to;
      bit hit;
      logic [7:0] g;
      clear(); cur_sh = 0; lat = 4; rdy_mode = 0;
      pulse_start(22'h100, 1'b0, 16'd6);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (rx_q.size() >= 2) begin hit = 1'b1; break; end
      end
      rdy_mode = 2;
      n_vec++;
      if (!hit) begin n_err++; $display("FAIL abort_two_bytes: got %0d bytes want 2", rx_q.size()); end
      // Wait for the next word to sit stalled and the following read to be in flight.
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (wr_valid && req_q.size() >= 3) begin hit = 1'b1; break; end
      end
      n_vec++;
      if (!(hit && wr_valid === 1'b1 && wr_data === 8'h33)) begin
         n_err++; $display("FAIL abort_stalled: got valid=%b data=%h want valid=1 data=33", wr_valid, wr_data);
      end
      closed = 1'b1;
      @(negedge clk); #1;
      n_vec++;
      if ({wr_valid, done, aborted, active} !== 4'b0110) begin
         n_err++;
         $display("FAIL abort_end: got valid/done/aborted/active=%b want 0110", {wr_valid, done, aborted, active});
      end
      pulse_start(22'h100, 1'b0, 16'd2);
      @(negedge clk); #1;
      n_vec++;
      if (active !== 1'b0) begin n_err++; $display("FAIL abort_start_ignored: got active=%b want 0", active); end
      repeat (12) @(negedge clk);
      #1;
      n_vec++;
      if (rx_q.size() != 2 || req_q.size() != 3 || done_cnt != 1) begin
         n_err++;
         $display("FAIL abort_quiet: got %0d bytes %0d reqs %0d dones want 2 3 1",
                  rx_q.size(), req_q.size(), done_cnt);
      end
      closed = 1'b0; rdy_mode = 0; lat = 1;
      repeat (2) @(negedge clk);
      clear();
      pulse_start(22'h101, 1'b0, 16'd2);
      wait_done(300, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL restart_timeout: done=0 want done within 300 cycles"); end
      g = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
      n_vec++;
      if (!(rx_q.size() == 2 && rx_q[0] === 8'h33 && g === 8'h44)) begin
         n_err++; $display("FAIL restart_bytes: got %p want 33 44", rx_q);
      end
      n_vec++;
      if (!(req_q.size() == 1 && req_q[0] === 22'h101 && last_aborted === 1'b0)) begin
         n_err++; $display("FAIL restart_reqs: got %p aborted=%b want 000101 aborted=0", req_q, last_aborted);
      end
   endtask

   task automatic test_reset_mid();
      bit hit;
      clear(); cur_sh = 0; lat = 4; rdy_mode = 2;
      pulse_start(22'h100, 1'b0, 16'd6);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (ram_req && ram_address == 22'h101) begin hit = 1'b1; break; end
      end
      n_vec++;
      if (!(hit && active === 1'b1 && wr_valid === 1'b1)) begin
         n_err++; $display("FAIL rstmid_pre: got active=%b valid=%b want 1 1", active, wr_valid);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({active, done, aborted, ram_req, ram_we, wr_valid} !== 6'b0 || ram_address !== 22'h0 ||
          wr_data !== 8'h00) begin
         n_err++;
         $display("FAIL rstmid_outputs: got ctrl=%b addr=%h data=%h want 000000 000000 00",
                  {active, done, aborted, ram_req, ram_we, wr_valid}, ram_address, wr_data);
      end
      @(negedge clk);
      rst_n = 1'b1; rdy_mode = 0;
      repeat (10) @(negedge clk);
      #1;
      n_vec++;
      if (done_cnt != 0) begin n_err++; $display("FAIL rstmid_nodone: got %0d done pulses want 0", done_cnt); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clear();
      test_reset();
      test_sequential();
      test_start_high();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
